umi_mem_arbiter: RTL and testbench

- Two-host arbiter sharing one UMI memory device port, e.g. a single umi_mem_agent, between two UMI request/response host pairs.
- Round-robin grant on the request path, locked for the duration of a packet.
- An in-order grant-ID FIFO routes device responses back to the requesting host.
- Sits between host-side UMI agents/fabric and the memory agent DUT in memory-subsystem testbenches and SoC integration.

---
 rtl/umi_mem_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_umi_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_mem_arbiter.sv
// Two-host arbiter sharing one UMI memory device port, in-order response return.
// Latency: zero-cycle combinational request mux and response routing; grant is registered only while a packet is locked.
// Backpressure: device ready passes through to the granted host; response-expecting EOM beats stall while the ID FIFO is full.
//
// Ports:
//   clk, nreset                      clock, asynchronous active-low reset
//   uhost{0,1}_req_*                 host request channels (valid/ready, cmd/dstaddr/srcaddr/data)
//   uhost{0,1}_resp_*                host response channels (payload broadcast, valid qualified per host)
//   udev_req_*                       shared device request channel
//   udev_resp_*                      shared device response channel
//   outstanding                      number of grant IDs waiting for a response
// Build option: define UMI_MEM_ARB_FIXED_PRIO_EN for fixed priority (host0 always wins when idle).

module umi_mem_arbiter #(
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 256,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     nreset,
  // host 0 request / response
  input  logic                     uhost0_req_valid,
  output logic                     uhost0_req_ready,
  input  logic [CW-1:0]            uhost0_req_cmd,
  input  logic [AW-1:0]            uhost0_req_dstaddr,
  input  logic [AW-1:0]            uhost0_req_srcaddr,
  input  logic [DW-1:0]            uhost0_req_data,
  output logic                     uhost0_resp_valid,
  input  logic                     uhost0_resp_ready,
  output logic [CW-1:0]            uhost0_resp_cmd,
  output logic [AW-1:0]            uhost0_resp_dstaddr,
  output logic [AW-1:0]            uhost0_resp_srcaddr,
  output logic [DW-1:0]            uhost0_resp_data,
  // host 1 request / response
  input  logic                     uhost1_req_valid,
  output logic                     uhost1_req_ready,
  input  logic [CW-1:0]            uhost1_req_cmd,
  input  logic [AW-1:0]            uhost1_req_dstaddr,
  input  logic [AW-1:0]            uhost1_req_srcaddr,
  input  logic [DW-1:0]            uhost1_req_data,
  output logic                     uhost1_resp_valid,
  input  logic                     uhost1_resp_ready,
  output logic [CW-1:0]            uhost1_resp_cmd,
  output logic [AW-1:0]            uhost1_resp_dstaddr,
  output logic [AW-1:0]            uhost1_resp_srcaddr,
  output logic [DW-1:0]            uhost1_resp_data,
  // device request / response
  output logic                     udev_req_valid,
  input  logic                     udev_req_ready,
  output logic [CW-1:0]            udev_req_cmd,
  output logic [AW-1:0]            udev_req_dstaddr,
  output logic [AW-1:0]            udev_req_srcaddr,
  output logic [DW-1:0]            udev_req_data,
  input  logic                     udev_resp_valid,
  output logic                     udev_resp_ready,
  input  logic [CW-1:0]            udev_resp_cmd,
  input  logic [AW-1:0]            udev_resp_dstaddr,
  input  logic [AW-1:0]            udev_resp_srcaddr,
  input  logic [DW-1:0]            udev_resp_data,
  // status
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  localparam logic [4:0] OP_REQ_LINK   = 5'h00;
  localparam logic [4:0] OP_REQ_POSTED = 5'h05;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t           r_state;
  logic             r_lock_gnt;
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic [DEPTH-1:0] r_ids;

  logic             w_gnt_idle;
  logic             w_gnt;
  logic             w_sel_vld;
  logic [CW-1:0]    w_sel_cmd;
  logic [4:0]       w_opcode;
  logic             w_eom;
  logic             w_needs_resp;
  logic             w_full;
  logic             w_empty;
  logic             w_block;
  logic             w_req_rdy;
  logic             w_req_hs;
  logic             w_push;
  logic             w_pop;
  logic             w_head;

  // ---------------------------------------------------------------------------
  // Idle grant selection
  // ---------------------------------------------------------------------------
`ifdef UMI_MEM_ARB_FIXED_PRIO_EN
  // host0 always wins; host1 only gets the port when host0 is silent
  assign w_gnt_idle = ~uhost0_req_valid & uhost1_req_valid;
`else
  // r_last holds the host served by the most recent completed packet.
  // Reset value 1 makes host0 the first winner on a tie.
  logic r_last;

  assign w_gnt_idle = (uhost0_req_valid & uhost1_req_valid) ? ~r_last : uhost1_req_valid;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_last <= 1'b1;
    end else if (w_req_hs & w_eom) begin
      r_last <= w_gnt;
    end
  end
`endif

  // Locked grant keeps the device stream stable across a multi-beat packet
  // and across a stalled beat (valid without ready).
  assign w_gnt = (r_state == ST_LOCKED) ? r_lock_gnt : w_gnt_idle;

  // ---------------------------------------------------------------------------
  // Request datapath
  // ---------------------------------------------------------------------------
  assign w_sel_vld        = w_gnt ? uhost1_req_valid   : uhost0_req_valid;
  assign w_sel_cmd        = w_gnt ? uhost1_req_cmd     : uhost0_req_cmd;
  assign udev_req_cmd     = w_sel_cmd;
  assign udev_req_dstaddr = w_gnt ? uhost1_req_dstaddr : uhost0_req_dstaddr;
  assign udev_req_srcaddr = w_gnt ? uhost1_req_srcaddr : uhost0_req_srcaddr;
  assign udev_req_data    = w_gnt ? uhost1_req_data    : uhost0_req_data;

  assign w_opcode     = w_sel_cmd[4:0];
  assign w_eom        = w_sel_cmd[22];
  assign w_needs_resp = (w_opcode != OP_REQ_POSTED) && (w_opcode != OP_REQ_LINK);

  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_empty = (r_wptr == r_rptr);

  // Only the final beat of a response-expecting packet consumes an ID slot,
  // so only that beat is held back when no slot is free. A pop in the same
  // cycle does not release it; the beat goes out the following cycle.
  assign w_block = w_needs_resp & w_eom & w_full;

  // Outputs are forced low while reset is asserted, independent of the clock.
  assign udev_req_valid   = nreset & w_sel_vld & ~w_block;
  assign w_req_rdy        = nreset & udev_req_ready & ~w_block;
  assign uhost0_req_ready = w_req_rdy & ~w_gnt;
  assign uhost1_req_ready = w_req_rdy &  w_gnt;

  assign w_req_hs = udev_req_valid & udev_req_ready;
  assign w_push   = w_req_hs & w_eom & w_needs_resp;

  // ---------------------------------------------------------------------------
  // Response routing: head of the ID FIFO owns the response channel
  // ---------------------------------------------------------------------------
  assign w_head = r_ids[r_rptr[PW-1:0]];

  assign uhost0_resp_valid = nreset & udev_resp_valid & ~w_empty & ~w_head;
  assign uhost1_resp_valid = nreset & udev_resp_valid & ~w_empty &  w_head;
  assign udev_resp_ready   = nreset & ~w_empty & (w_head ? uhost1_resp_ready : uhost0_resp_ready);

  assign uhost0_resp_cmd     = udev_resp_cmd;
  assign uhost0_resp_dstaddr = udev_resp_dstaddr;
  assign uhost0_resp_srcaddr = udev_resp_srcaddr;
  assign uhost0_resp_data    = udev_resp_data;
  assign uhost1_resp_cmd     = udev_resp_cmd;
  assign uhost1_resp_dstaddr = udev_resp_dstaddr;
  assign uhost1_resp_srcaddr = udev_resp_srcaddr;
  assign uhost1_resp_data    = udev_resp_data;

  // Multi-beat responses stay on the same head until their EOM beat.
  assign w_pop = udev_resp_valid & udev_resp_ready & udev_resp_cmd[22];

  assign outstanding = r_wptr - r_rptr;

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= ST_IDLE;
      r_lock_gnt <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // lock on anything other than a completed single-beat packet
          if (w_sel_vld & ~(w_req_hs & w_eom)) begin
            r_state    <= ST_LOCKED;
            r_lock_gnt <= w_gnt;
          end
        end
        ST_LOCKED: begin
          if (w_req_hs & w_eom) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Grant-ID FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ids  <= '0;
    end else begin
      if (w_push) begin
        r_ids[r_wptr[PW-1:0]] <= w_gnt;
        r_wptr                <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_umi_mem_arbiter.sv
module tb_umi_mem_arbiter;

  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;
  localparam int DEPTH = 8;
  localparam int OW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] RD   = 32'h0040_0001;  // REQ_READ, EOM
  localparam logic [CW-1:0] WR0  = 32'h0000_0003;  // REQ_WRITE, not last
  localparam logic [CW-1:0] WR1  = 32'h0040_0003;  // REQ_WRITE, last
  localparam logic [CW-1:0] PST  = 32'h0040_0005;  // REQ_POSTED, EOM
  localparam logic [CW-1:0] NONE = 32'h0000_0000;
  localparam logic [DW-1:0] HDATA0 = 256'hA0A0;
  localparam logic [DW-1:0] HDATA1 = 256'hB1B1;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic          uhost0_req_valid, uhost0_req_ready;
  logic [CW-1:0] uhost0_req_cmd;
  logic [AW-1:0] uhost0_req_dstaddr, uhost0_req_srcaddr;
  logic [DW-1:0] uhost0_req_data;
  logic          uhost0_resp_valid, uhost0_resp_ready;
  logic [CW-1:0] uhost0_resp_cmd;
  logic [AW-1:0] uhost0_resp_dstaddr, uhost0_resp_srcaddr;
  logic [DW-1:0] uhost0_resp_data;
  logic          uhost1_req_valid, uhost1_req_ready;
  logic [CW-1:0] uhost1_req_cmd;
  logic [AW-1:0] uhost1_req_dstaddr, uhost1_req_srcaddr;
  logic [DW-1:0] uhost1_req_data;
  logic          uhost1_resp_valid, uhost1_resp_ready;
  logic [CW-1:0] uhost1_resp_cmd;
  logic [AW-1:0] uhost1_resp_dstaddr, uhost1_resp_srcaddr;
  logic [DW-1:0] uhost1_resp_data;
  logic          udev_req_valid, udev_req_ready;
  logic [CW-1:0] udev_req_cmd;
  logic [AW-1:0] udev_req_dstaddr, udev_req_srcaddr;
  logic [DW-1:0] udev_req_data;
  logic          udev_resp_valid, udev_resp_ready;
  logic [CW-1:0] udev_resp_cmd;
  logic [AW-1:0] udev_resp_dstaddr, udev_resp_srcaddr;
  logic [DW-1:0] udev_resp_data;
  logic [OW-1:0] outstanding;

  umi_mem_arbiter #(.CW(CW), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .nreset(nreset),
    .uhost0_req_valid(uhost0_req_valid), .uhost0_req_ready(uhost0_req_ready),
    .uhost0_req_cmd(uhost0_req_cmd), .uhost0_req_dstaddr(uhost0_req_dstaddr),
    .uhost0_req_srcaddr(uhost0_req_srcaddr), .uhost0_req_data(uhost0_req_data),
    .uhost0_resp_valid(uhost0_resp_valid), .uhost0_resp_ready(uhost0_resp_ready),
    .uhost0_resp_cmd(uhost0_resp_cmd), .uhost0_resp_dstaddr(uhost0_resp_dstaddr),
    .uhost0_resp_srcaddr(uhost0_resp_srcaddr), .uhost0_resp_data(uhost0_resp_data),
    .uhost1_req_valid(uhost1_req_valid), .uhost1_req_ready(uhost1_req_ready),
    .uhost1_req_cmd(uhost1_req_cmd), .uhost1_req_dstaddr(uhost1_req_dstaddr),
    .uhost1_req_srcaddr(uhost1_req_srcaddr), .uhost1_req_data(uhost1_req_data),
    .uhost1_resp_valid(uhost1_resp_valid), .uhost1_resp_ready(uhost1_resp_ready),
    .uhost1_resp_cmd(uhost1_resp_cmd), .uhost1_resp_dstaddr(uhost1_resp_dstaddr),
    .uhost1_resp_srcaddr(uhost1_resp_srcaddr), .uhost1_resp_data(uhost1_resp_data),
    .udev_req_valid(udev_req_valid), .udev_req_ready(udev_req_ready),
    .udev_req_cmd(udev_req_cmd), .udev_req_dstaddr(udev_req_dstaddr),
    .udev_req_srcaddr(udev_req_srcaddr), .udev_req_data(udev_req_data),
    .udev_resp_valid(udev_resp_valid), .udev_resp_ready(udev_resp_ready),
    .udev_resp_cmd(udev_resp_cmd), .udev_resp_dstaddr(udev_resp_dstaddr),
    .udev_resp_srcaddr(udev_resp_srcaddr), .udev_resp_data(udev_resp_data),
    .outstanding(outstanding)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic exp_q[$];  // expected host ID for each response, in request order

  typedef struct {
    logic          h0v;
    logic [CW-1:0] h0c;
    logic          h1v;
    logic [CW-1:0] h1c;
    logic          drdy;
    logic          e_dvld;
    logic          e_src;
    logic          e_h0r;
    logic          e_h1r;
    logic [OW-1:0] e_out;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic expects_resp(input logic [CW-1:0] c);
    return c[22] && (c[4:0] != 5'h05) && (c[4:0] != 5'h00);
  endfunction

  // One device response beat; routing and payload checked against scoreboard head.
  task automatic resp_beat(input logic eom, input logic [DW-1:0] tag);
    logic h;
    udev_resp_valid = 1'b1;
    udev_resp_cmd   = eom ? 32'h0040_000B : 32'h0000_000B;
    udev_resp_data  = tag;
    #3;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL resp_beat: response with no expected entry, got %0d, expected %0d", 1, 0);
    end else begin
      h = exp_q[0];
      chk("resp h0 valid", 256'(uhost0_resp_valid), 256'(h == 1'b0));
      chk("resp h1 valid", 256'(uhost1_resp_valid), 256'(h == 1'b1));
      chk("resp dev ready", 256'(udev_resp_ready), 256'(1'b1));
      chk("resp data", h ? uhost1_resp_data : uhost0_resp_data, tag);
      if (eom) void'(exp_q.pop_front());
    end
    tick();
    udev_resp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time budget exceeded, got %0d, expected %0d", 1, 0);
    $fatal(1);
  end

  initial begin
    // RR rows: host0 wins the first tie; locks hold through stalls and multi-beat packets.
    tbl[0]  = '{1'b1, RD,   1'b1, RD,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, RD,   1'b1, RD,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1};
    tbl[2]  = '{1'b1, RD,   1'b1, RD,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};
    tbl[3]  = '{1'b1, RD,   1'b1, RD,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3};
    tbl[4]  = '{1'b1, RD,   1'b0, NONE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4};
    tbl[5]  = '{1'b1, RD,   1'b1, WR0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5};
    tbl[6]  = '{1'b1, RD,   1'b1, WR0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5};
    tbl[7]  = '{1'b1, RD,   1'b1, WR1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5};
    tbl[8]  = '{1'b1, RD,   1'b0, NONE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6};
    tbl[9]  = '{1'b0, NONE, 1'b1, WR0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7};
    tbl[10] = '{1'b1, RD,   1'b1, WR0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7};
    tbl[11] = '{1'b1, RD,   1'b1, WR0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7};
    tbl[12] = '{1'b1, RD,   1'b1, WR1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7};
    tbl[13] = '{1'b1, PST,  1'b0, NONE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8};
    tbl[14] = '{1'b1, RD,   1'b0, NONE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8};
    tbl[15] = '{1'b1, RD,   1'b1, RD,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8};

    // static payloads; srcaddr identifies the source host on the device side
    uhost0_req_dstaddr = 64'h1000; uhost0_req_srcaddr = 64'h0; uhost0_req_data = HDATA0;
    uhost1_req_dstaddr = 64'h2000; uhost1_req_srcaddr = 64'h1; uhost1_req_data = HDATA1;
    udev_resp_dstaddr  = 64'h0;    udev_resp_srcaddr  = 64'h0;
    udev_resp_cmd      = 32'h0040_000B; udev_resp_data = '0;

    // reset with every input active: all valids/readies must stay low
    nreset = 1'b0;
    uhost0_req_valid = 1'b1; uhost0_req_cmd = RD;
    uhost1_req_valid = 1'b1; uhost1_req_cmd = RD;
    udev_req_ready = 1'b1; udev_resp_valid = 1'b1;
    uhost0_resp_ready = 1'b1; uhost1_resp_ready = 1'b1;
    #4;
    chk("rst udev_req_valid", 256'(udev_req_valid), 256'(1'b0));
    chk("rst h0_req_ready", 256'(uhost0_req_ready), 256'(1'b0));
    chk("rst h1_req_ready", 256'(uhost1_req_ready), 256'(1'b0));
    chk("rst udev_resp_ready", 256'(udev_resp_ready), 256'(1'b0));
    chk("rst h0_resp_valid", 256'(uhost0_resp_valid), 256'(1'b0));
    chk("rst h1_resp_valid", 256'(uhost1_resp_valid), 256'(1'b0));
    chk("rst outstanding", 256'(outstanding), 256'(4'd0));
    uhost0_req_valid = 1'b0; uhost1_req_valid = 1'b0; udev_resp_valid = 1'b0;
    tick();
    nreset = 1'b1;

`ifdef UMI_MEM_ARB_FIXED_PRIO_EN
    uhost0_req_valid = 1'b1; uhost0_req_cmd = RD;
    uhost1_req_valid = 1'b1; uhost1_req_cmd = RD;
    for (int i = 0; i < 6; i++) begin
      #3;
      chk($sformatf("fixed%0d src", i), 256'(udev_req_srcaddr), 256'(64'h0));
      chk($sformatf("fixed%0d h0_rdy", i), 256'(uhost0_req_ready), 256'(1'b1));
      chk($sformatf("fixed%0d h1_rdy", i), 256'(uhost1_req_ready), 256'(1'b0));
      chk($sformatf("fixed%0d out", i), 256'(outstanding), 256'(i));
      tick();
    end
    uhost0_req_valid = 1'b0; uhost1_req_valid = 1'b0;
`else
    // ---------------- table-driven request path ----------------
    for (int i = 0; i < 16; i++) begin
      uhost0_req_valid = tbl[i].h0v; uhost0_req_cmd = tbl[i].h0c;
      uhost1_req_valid = tbl[i].h1v; uhost1_req_cmd = tbl[i].h1c;
      udev_req_ready   = tbl[i].drdy;
      #3;
      chk($sformatf("row%0d dev_vld", i), 256'(udev_req_valid), 256'(tbl[i].e_dvld));
      chk($sformatf("row%0d src", i), 256'(udev_req_srcaddr), 256'(tbl[i].e_src));
      chk($sformatf("row%0d data", i), udev_req_data, tbl[i].e_src ? HDATA1 : HDATA0);
      chk($sformatf("row%0d h0_rdy", i), 256'(uhost0_req_ready), 256'(tbl[i].e_h0r));
      chk($sformatf("row%0d h1_rdy", i), 256'(uhost1_req_ready), 256'(tbl[i].e_h1r));
      chk($sformatf("row%0d out", i), 256'(outstanding), 256'(tbl[i].e_out));
      if (tbl[i].e_dvld && tbl[i].drdy &&
          expects_resp(tbl[i].e_src ? tbl[i].h1c : tbl[i].h0c))
        exp_q.push_back(tbl[i].e_src);
      tick();
    end

    // ---------------- full FIFO: a pop frees the slot one cycle later ----------------
    resp_beat(1'b1, 256'h100);  // pop while host0 read is still blocked
    #3;
    chk("full pop-cycle dev_vld", 256'(udev_req_valid), 256'(1'b1));
    chk("full next src", 256'(udev_req_srcaddr), 256'(64'h0));
    chk("full next h0_rdy", 256'(uhost0_req_ready), 256'(1'b1));
    chk("full next out", 256'(outstanding), 256'(4'd7));
    exp_q.push_back(1'b0);
    tick();
    uhost0_req_valid = 1'b0;
    #3;
    chk("full h1 blocked dev_vld", 256'(udev_req_valid), 256'(1'b0));
    chk("full h1 blocked rdy", 256'(uhost1_req_ready), 256'(1'b0));
    chk("full h1 out", 256'(outstanding), 256'(4'd8));
    tick();
    resp_beat(1'b1, 256'h101);
    #3;
    chk("full h1 accepted", 256'(uhost1_req_ready), 256'(1'b1));
    chk("full h1 src", 256'(udev_req_srcaddr), 256'(64'h1));
    exp_q.push_back(1'b1);
    tick();
    uhost1_req_valid = 1'b0;

    // ---------------- response backpressure at host0 ----------------
    uhost0_resp_ready = 1'b0;
    udev_resp_valid = 1'b1; udev_resp_cmd = 32'h0040_000B; udev_resp_data = 256'hDEAD;
    for (int i = 0; i < 10; i++) begin
      #3;
      chk($sformatf("bp%0d dev_rdy", i), 256'(udev_resp_ready), 256'(1'b0));
      chk($sformatf("bp%0d h0_vld", i), 256'(uhost0_resp_valid), 256'(1'b1));
      chk($sformatf("bp%0d h0_data", i), uhost0_resp_data, 256'hDEAD);
      chk($sformatf("bp%0d out", i), 256'(outstanding), 256'(4'd8));
      tick();
    end
    uhost0_resp_ready = 1'b1;
    resp_beat(1'b1, 256'hDEAD);

    // multi-beat response stays on one head and pops once
    resp_beat(1'b0, 256'h51);
    chk("multibeat out held", 256'(outstanding), 256'(4'd7));
    resp_beat(1'b1, 256'h52);
    chk("multibeat out popped", 256'(outstanding), 256'(4'd6));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) resp_beat(1'b1, 256'(i + 'h60));
    chk("drain out", 256'(outstanding), 256'(4'd0));

    // empty FIFO: a stray device response is never forwarded
    udev_resp_valid = 1'b1;
    #3;
    chk("empty dev_rdy", 256'(udev_resp_ready), 256'(1'b0));
    chk("empty h0_vld", 256'(uhost0_resp_valid), 256'(1'b0));
    chk("empty h1_vld", 256'(uhost1_resp_valid), 256'(1'b0));
    tick();
    udev_resp_valid = 1'b0;

    // ---------------- posted writes never occupy an ID ----------------
    uhost0_req_valid = 1'b1; uhost0_req_cmd = PST; udev_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk($sformatf("posted%0d h0_rdy", i), 256'(uhost0_req_ready), 256'(1'b1));
      chk($sformatf("posted%0d out", i), 256'(outstanding), 256'(4'd0));
      tick();
    end
    uhost0_req_valid = 1'b0;
    #3;
    chk("posted no resp", 256'(uhost0_resp_valid), 256'(1'b0));
    chk("posted final out", 256'(outstanding), 256'(4'd0));
    tick();

    // ---------------- reset in the middle of a locked packet ----------------
    uhost0_req_valid = 1'b1; uhost0_req_cmd = RD;
    tick();
    uhost0_req_valid = 1'b0;
    uhost1_req_valid = 1'b1; uhost1_req_cmd = WR0;
    tick();
    uhost0_req_valid = 1'b1;
    udev_resp_valid = 1'b1;
    #1;
    chk("prerst h1_rdy", 256'(uhost1_req_ready), 256'(1'b1));
    chk("prerst h0_resp_vld", 256'(uhost0_resp_valid), 256'(1'b1));
    #1;
    nreset = 1'b0;
    #1;
    chk("midrst dev_vld", 256'(udev_req_valid), 256'(1'b0));
    chk("midrst h0_rdy", 256'(uhost0_req_ready), 256'(1'b0));
    chk("midrst h1_rdy", 256'(uhost1_req_ready), 256'(1'b0));
    chk("midrst h0_resp_vld", 256'(uhost0_resp_valid), 256'(1'b0));
    chk("midrst dev_resp_rdy", 256'(udev_resp_ready), 256'(1'b0));
    chk("midrst out", 256'(outstanding), 256'(4'd0));
    tick();
    udev_resp_valid = 1'b0;
    nreset = 1'b1;
    exp_q.delete();
    #3;
    chk("postrst src", 256'(udev_req_srcaddr), 256'(64'h0));
    chk("postrst h0_rdy", 256'(uhost0_req_ready), 256'(1'b1));
    tick();
    uhost0_req_valid = 1'b0; uhost1_req_valid = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
